// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate packer.
//   Format codes (same code space as the core's imm_src), per-code field
//   width table, packed field width, FSM state enum, registered request
//   struct and a field masking helper.
// Build option: IMM_PACK_SPLIT_EN adds the HI/LO states that split a
//   non-fitting signed constant into an upper-20 beat plus a low-12 beat.
package imm_pkg;

    localparam int IMM_W = 26;

    localparam logic [3:0] SRC_S12 = 4'd0;
    localparam logic [3:0] SRC_S16 = 4'd1;
    localparam logic [3:0] SRC_S20 = 4'd2;
    localparam logic [3:0] SRC_S26 = 4'd3;
    localparam logic [3:0] SRC_U20 = 4'd4;

`ifdef IMM_PACK_SPLIT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ONE, ST_HI, ST_LO} state_t;
`else
    typedef enum logic {ST_IDLE, ST_ONE} state_t;
`endif

    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  src;
        logic [4:0]  width;
        logic        err;
    } req_t;

    // Field width per format code; 0 marks a reserved code.
    function automatic logic [4:0] src_width(input logic [3:0] src);
        case (src)
            SRC_S12: return 5'd12;
            SRC_S16: return 5'd16;
            SRC_S20: return 5'd20;
            SRC_S26: return 5'd26;
            SRC_U20: return 5'd20;
            default: return 5'd0;
        endcase
    endfunction

    // Keep bits [w-1:0] of a field, clear the rest.
    function automatic logic [IMM_W-1:0] keep_low(input logic [IMM_W-1:0] v,
                                                  input logic [4:0] w);
        logic [IMM_W-1:0] r;
        for (int i = 0; i < IMM_W; i++)
            r[i] = (i < int'(w)) ? v[i] : 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// imm_fit_check -- combinational fit test for one constant.
//   value    : constant to encode
//   src      : requested format code
//   fits     : constant is representable in the format
//   reserved : src is a reserved code (fits is 0)
//   width    : field width of the format (0 when reserved)
module imm_fit_check
    import imm_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  src,
    output logic        fits,
    output logic        reserved,
    output logic [4:0]  width
);

    always_comb begin
        width    = src_width(src);
        reserved = (width == 5'd0);
        fits     = 1'b0;
        if (src == SRC_U20) begin
            fits = (value[11:0] == 12'd0);
        end else if (!reserved) begin
            // Signed fit: every bit from the field's sign bit up matches value[31].
            fits = 1'b1;
            for (int i = 0; i < 32; i++)
                if (i >= int'(width) - 1 && value[i] != value[31])
                    fits = 1'b0;
        end
    end

endmodule

// File: rtl/imm_pack.sv
// imm_pack -- packs a 32-bit constant into a 26-bit immediate field
//   (destined for instr[31:6]) in the format selected by in_src.
//   in_valid/in_ready/in_value/in_src : request handshake, accepted in IDLE only
//   out_valid/out_ready               : beat handshake
//   out_imm/out_src/out_last/out_err  : packed field, its format, last-beat
//                                       and not-encodable flags
// Outputs are decoded from the state register and the registered request
// only, so there is no combinational path from in_* to out_*, and they
// hold while a beat is stalled.
// Build option: IMM_PACK_SPLIT_EN -- a signed constant that does not fit
//   goes out as two beats: upper-20 (rounded for the low part's sign)
//   followed by the sign-extended low 12 bits in the requested format.
module imm_pack
    import imm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [3:0]       in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic [3:0]       out_src,
    output logic             out_last,
    output logic             out_err
);

    state_t     state, state_nxt;
    req_t       req;
    logic       fits, reserved, split_ok;
    logic [4:0] width;

    imm_fit_check u_fit (
        .value    (in_value),
        .src      (in_src),
        .fits     (fits),
        .reserved (reserved),
        .width    (width)
    );

`ifdef IMM_PACK_SPLIT_EN
    // Only the signed formats can be split; upper-20 misfits stay errors.
    assign split_ok = (in_src <= SRC_S26);
`else
    assign split_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            req   <= '0;
        end else begin
            state <= state_nxt;
            if (in_ready && in_valid) begin
                req.value <= in_value;
                req.src   <= in_src;
                req.width <= width;
                req.err   <= reserved | (~fits & ~split_ok);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        out_imm   = '0;
        out_src   = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef IMM_PACK_SPLIT_EN
                    state_nxt = (!fits && split_ok) ? ST_HI : ST_ONE;
`else
                    state_nxt = ST_ONE;
`endif
                end
            end
            ST_ONE: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_err   = req.err;
                out_src   = req.src;
                if (req.err)
                    out_imm = '0;
                else if (req.src == SRC_U20)
                    out_imm = {6'd0, req.value[31:12]};
                else
                    out_imm = keep_low(req.value[IMM_W-1:0], req.width);
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
`ifdef IMM_PACK_SPLIT_EN
            ST_HI: begin
                // +0x800 pre-compensates for the low beat being sign-extended.
                out_valid = 1'b1;
                out_src   = SRC_U20;
                out_imm   = {6'd0, 20'((req.value + 32'h800) >> 12)};
                if (out_ready)
                    state_nxt = ST_LO;
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_src   = req.src;
                out_imm   = keep_low({{(IMM_W-12){req.value[11]}}, req.value[11:0]},
                                     req.width);
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack -- randomized and directed bench for imm_pack with an
// arithmetic reference model of the expected beat sequence.
module tb_imm_pack;

`ifdef IMM_PACK_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_err;
    logic [31:0] in_value;
    logic [3:0]  in_src, out_src;
    logic [25:0] out_imm;
    logic [31:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    imm_pack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_src(in_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_src(out_src),
        .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    assign obs = {out_imm, out_src, out_last, out_err};

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // Expected beats as {imm[25:0], src[3:0], last, err}.
    function automatic void model(input logic [31:0] v, input logic [3:0] s,
                                  output int n, output logic [31:0] b0,
                                  output logic [31:0] b1);
        int     w;
        longint sv, lim, m, uv, lo;
        logic [31:0] errb;
        sv   = longint'($signed(v));
        uv   = longint'(v);
        n    = 1;
        b1   = '0;
        errb = {26'd0, s, 1'b1, 1'b1};
        case (s)
            4'd0: w = 12;
            4'd1: w = 16;
            4'd2: w = 20;
            4'd3: w = 26;
            4'd4: w = 20;
            default: w = 0;
        endcase
        if (w == 0) begin
            b0 = errb;
        end else if (s == 4'd4) begin
            if (uv % 4096 == 0) b0 = {26'(uv / 4096), s, 1'b1, 1'b0};
            else                b0 = errb;
        end else begin
            lim = 64'sd1 <<< (w - 1);
            m   = (64'sd1 <<< w) - 1;
            if (sv >= -lim && sv < lim) begin
                b0 = {26'(sv & m), s, 1'b1, 1'b0};
            end else if (SPLIT) begin
                n  = 2;
                b0 = {26'(((uv + 2048) % (64'sd1 <<< 32)) / 4096), 4'd4, 1'b0, 1'b0};
                lo = uv % 4096;
                if (lo >= 2048) lo = lo - 4096;
                b1 = {26'(lo & m), s, 1'b1, 1'b0};
            end else begin
                b0 = errb;
            end
        end
    endfunction

    // Consume n beats at negedges, random stalls (forced ready after 6).
    task automatic collect(input int n, input logic [31:0] b0, input logic [31:0] b1,
                           input int stall_pct, input string name);
        logic [31:0] exp;
        int k;
        for (int i = 0; i < n; i++) begin
            exp = (i == 0) ? b0 : b1;
            k = 0;
            forever begin
                n_tests++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp) begin
                    n_fail++;
                    $display("FAIL %s beat%0d: valid=%b in_ready=%b got=%h required=%h",
                             name, i, out_valid, in_ready, obs, exp);
                end
                out_ready = (k >= 6) || ($urandom_range(99) >= stall_pct);
                k++;
                @(negedge clk);
                if (out_ready) break;
            end
        end
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_after: valid=%b in_ready=%b required valid=0 in_ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic do_req(input logic [31:0] v, input logic [3:0] s,
                          input int stall_pct, input string name);
        int n;
        logic [31:0] b0, b1;
        model(v, s, n, b0, b1);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got=%b required=1", name, in_ready);
        end
        in_valid = 1'b1; in_value = v; in_src = s; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_value = $urandom; in_src = 4'($urandom);
        collect(n, b0, b1, stall_pct, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_value = 32'h7FF; in_src = 4'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b in_ready=%b outs=%h required 0/1/0",
                     out_valid, in_ready, obs);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b in_ready=%b outs=%h required 0/1/0",
                     out_valid, in_ready, obs);
        end
    endtask

    task automatic test_directed();
        do_req(32'h0000_07FF, 4'd0, 0, "s12_max");
        do_req(32'hFFFF_F800, 4'd0, 0, "s12_min");
        do_req(32'h1234_5FFF, 4'd0, 0, "split_or_err");
        do_req(32'h0000_0800, 4'd0, 0, "s12_over");
        do_req(32'h0000_7FFF, 4'd1, 0, "s16_max");
        do_req(32'hFFF8_0000, 4'd2, 0, "s20_min");
        do_req(32'h01FF_FFFF, 4'd3, 0, "s26_max");
        do_req(32'h0200_0000, 4'd3, 0, "s26_over");
        do_req(32'h1234_5678, 4'd7, 0, "reserved7");
        do_req(32'h0000_0000, 4'd15, 0, "reserved15");
        do_req(32'hABCD_E000, 4'd4, 0, "u20_ok");
        do_req(32'hABCD_E001, 4'd4, 0, "u20_err");
        do_req(32'h7FFF_F800, 4'd1, 0, "split_carry");
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] b0, b1;
        model(32'h1234_5FFF, 4'd0, n, b0, b1);
        in_valid = 1'b1; in_value = 32'h1234_5FFF; in_src = 4'd0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b in_ready=%b got=%h required=%h",
                         i, out_valid, in_ready, obs, b0);
            end
            in_value = $urandom; in_src = 4'($urandom);
            @(negedge clk);
        end
        collect(n, b0, b1, 0, "stall_drain");
    endtask

    // in_valid held across the whole first request: B must not slip in early.
    task automatic test_back_to_back();
        int na, nb;
        logic [31:0] a0, a1, c0, c1;
        model(32'h1234_5FFF, 4'd0, na, a0, a1);
        model(32'hFFFF_FFFF, 4'd1, nb, c0, c1);
        in_valid = 1'b1; in_value = 32'h1234_5FFF; in_src = 4'd0; out_ready = 1'b0;
        @(negedge clk);
        in_value = 32'hFFFF_FFFF; in_src = 4'd1;
        collect(na, a0, a1, 0, "b2b_first");
        @(negedge clk);
        in_valid = 1'b0;
        collect(nb, c0, c1, 0, "b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [3:0]  s;
        int r, t;
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            s = (r < 8) ? 4'(r % 5) : 4'($urandom_range(5, 15));
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: begin t = int'($urandom_range(0, 65535)) - 32768; v = 32'(t); end
                2: v = $urandom & 32'hFFFF_F000;
                default: begin t = int'($urandom_range(0, 2**22)) - 2**21; v = 32'(t); end
            endcase
            do_req(v, s, 40, "random");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] b0, b1;
        model(32'h1234_5FFF, 4'd0, n, b0, b1);
        in_valid = 1'b1; in_value = 32'h1234_5FFF; in_src = 4'd0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (n == 2) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        n_tests++;
        if (out_valid !== 1'b1 || obs !== ((n == 2) ? b1 : b0)) begin
            n_fail++;
            $display("FAIL mid_last_beat: valid=%b got=%h required=%h", out_valid, obs,
                     (n == 2) ? b1 : b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b in_ready=%b outs=%h required 0/1/0",
                     out_valid, in_ready, obs);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_discard: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_src = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 in_valid  input  1  request carries a constant to encode.
REQ-004 in_ready  output  1  block accepts a request this cycle.
REQ-005 in_value  input  32  constant to place into an immediate field.
REQ-006 in_src  input  4  target immediate format, same code space as the core's imm_src.
REQ-007 out_valid  output  1  output beat present.
REQ-008 out_ready  input  1  consumer takes the beat this cycle.
REQ-009 out_imm  output  26  packed field, destined for instr[31:6].
REQ-010 out_src  output  4  format code of this beat.
REQ-011 out_last  output  1  final beat of the request.
REQ-012 out_err  output  1  request not encodable; out_imm is 0 on this beat.

Function
REQ-013 Formats: 0000 signed 12b; 0001 signed 16b; 0010 signed 20b; 0011 signed 26b; 0100 upper 20b (value[31:12], value[11:0] must be 0); codes 0101-1111 reserved.
REQ-014 Packing: field width W in out_imm[W-1:0]; out_imm[25:W] = 0.
REQ-015 Fit: signed format fits iff in_value[31:W-1] is all-0 or all-1; upper format fits iff in_value[11:0]==0.
REQ-016 FSM states: IDLE, ONE, HI, LO; in_ready=1 only in IDLE.
REQ-017 IDLE + in_valid: register inputs; next state ONE if fits or error, HI if split applies.
REQ-018 Latency: first beat out_valid=1 the cycle after acceptance; no combinational path from in_* to out_*.
REQ-019 ONE: out_last=1; on out_ready go IDLE.
REQ-020 HI: out_src=0100, out_imm[19:0]=(value+0x800)>>12 (32-bit add, carry out discarded), out_last=0; on out_ready go LO.
REQ-021 LO: out_src=requested code, out_imm = value[11:0] sign-extended to W, out_last=1; on out_ready go IDLE.
REQ-022 While out_valid && !out_ready, all out_* hold stable.
REQ-023 Reserved code, or no fit with split unavailable: single beat, out_err=1, out_imm=0, out_src=in_src, out_last=1.
REQ-024 out_err=0 on every non-error beat.
REQ-025 Back-to-back: no new request is accepted in the cycle the last beat is taken; earliest acceptance is the following cycle (IDLE).

Reset
REQ-026 rst_n low at a clock edge: state=IDLE, out_valid=0, out_last=0, out_err=0, out_imm=0, out_src=0; in_ready=1 the cycle after.
REQ-027 Reset mid-request (ONE/HI/LO) discards the request with no further beats.

Configuration
REQ-028 IMM_PACK_SPLIT_EN defined: non-fitting value for signed format 0000-0011 uses HI/LO split (REQ-020/021).
REQ-029 IMM_PACK_SPLIT_EN undefined: HI and LO states absent; non-fitting value is an error per REQ-023.
REQ-030 Upper format 0100 never splits; misfit is always an error.

Structure
REQ-031 Shared package imm_pkg holds the imm_src code constants, a per-code width table, the field width 26, and the FSM state enum.
REQ-032 One sub-module, imm_fit_check (combinational: value, src -> fits, reserved, W), is natural and shall be used.

Verification
REQ-033 in_value=0x000007FF, src=0000 -> one beat, out_imm=0x00007FF, last=1, err=0.
REQ-034 in_value=0xFFFFF800, src=0000 -> one beat, out_imm=0x0000800.
REQ-035 SPLIT_EN, in_value=0x12345FFF, src=0000 -> beat1 src=0100, out_imm=0x12346, last=0; beat2 src=0000, out_imm=0xFFF, last=1.
REQ-036 No SPLIT_EN, same stimulus -> one beat, err=1, out_imm=0, last=1.
REQ-037 src=0111 any value -> err=1; src=0100, value 0xABCDE000 -> out_imm=0xABCDE; value 0xABCDE001 -> err=1.
REQ-038 out_ready held 0 for 3 cycles during HI -> outputs stable, in_ready=0; rst_n low during LO -> next cycle out_valid=0, in_ready=1.
